led_pattern_gen: RTL and testbench
==================================

Name: led_pattern_gen

Overview:
- Parametrised LED pattern generator for the board LED bank.
- Steps an N-bit output pattern once per prescaled tick. Four run-time-selectable modes: fill-from-MSB, fill-from-LSB, running dot, ping-pong dot.
- Replaces hard-coded 8-bit, every-clock pattern blocks. Drives board LEDs directly.
- Exports step and wrap pulses so other display logic can stay in sync.

Parameters:
- WIDTH, 8, number of LED outputs; legal range 2..32.
- DIV, 50_000_000, clk cycles per pattern step; legal range >= 1.
- CW, $clog2(DIV) (minimum 1), prescaler counter width; derived, not overridden.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  run enable. Low: prescaler and pattern hold.
- mode  in  2  0=FILL_L, 1=FILL_R, 2=RUN_DOT, 3=PING_PONG.
- out  out  WIDTH  LED pattern, registered.
- step  out  1  one-cycle pulse, high in the cycle out takes a new step value.
- wrap  out  1  one-cycle pulse, high in the cycle out returns to the mode's initial pattern via stepping.

Behaviour:
- Initial pattern INIT(m):
  - FILL_L / FILL_R: all zeros.
  - RUN_DOT / PING_PONG: MSB only (1000...0).
- Reset, on a clk edge with reset=1:
  - out = INIT(mode), mode_q = mode, prescaler = 0, dir = right (toward LSB).
  - step = 0, wrap = 0.
- Prescaler:
  - When en=1, it counts 0..DIV-1. tick = en && (cnt == DIV-1); on tick, cnt returns to 0.
  - DIV=1 gives a tick every enabled cycle.
  - en=0 freezes cnt and out.
- Mode change:
  - Every cycle, if mode != mode_q: out <= INIT(mode), mode_q <= mode, cnt <= 0, dir <= right, step = wrap = 0.
  - This takes priority over a coincident tick; that tick is discarded.
  - It applies even when en=0.
- Step rules on tick (step=1 in the same cycle out updates, i.e. out changes at the edge where step is registered high):
  - FILL_L: if all ones -> all zeros, wrap=1. Else out <= {1'b1, out[W-1:1]}. Period WIDTH+1.
  - FILL_R: if all ones -> all zeros, wrap=1. Else out <= {out[W-2:0], 1'b1}. Period WIDTH+1.
  - RUN_DOT: out <= rotate right by 1; wrap=1 when the result is the MSB-only pattern. Period WIDTH.
  - PING_PONG: one-hot dot moves in direction dir.
    - Reaching bit 0: dir flips to left.
    - Reaching bit W-1 while moving left: dir flips to right, wrap=1.
    - Period 2*WIDTH-2.
- Robustness: in RUN_DOT / PING_PONG, if out is not one-hot at a tick (e.g. upset), the next value is INIT with wrap=1.
- step and wrap are registered and never high outside a tick cycle.
- Reset mid-sequence: the pattern aborts immediately and the next cycle shows INIT(mode).
- out changes only on reset, mode change or tick. No combinational path from inputs to out.

Test Plan:
- WIDTH=4, DIV=1, mode=0, en=1 after reset -> out 0000,1000,1100,1110,1111,0000 on consecutive cycles. wrap high only with the 0000 step. step high every cycle.
- WIDTH=4, DIV=3, mode=2 -> out 1000 after reset. 0100 after 3 enabled cycles, then 0010, 0001, 1000 at 3-cycle spacing. wrap with the return to 1000.
- WIDTH=4, DIV=1, mode=3 -> 1000,0100,0010,0001,0010,0100,1000. wrap only on the final 1000. Repeats with period 6.
- WIDTH=4, DIV=3, mode=1, en dropped for 5 cycles mid-count at out=0011 -> out and cnt frozen. After en returns, the next step to 0111 takes exactly the remaining count.
- WIDTH=4, DIV=1, mode switched 0->2 in a tick cycle with out=1100 -> next out 1000, step=0, wrap=0. Stepping resumes the following cycle with 0100.
- WIDTH=8, DIV=2, mode=3, reset asserted while out=00000100 moving left -> out 10000000 and dir right next cycle. Next step gives 01000000.

Source files
------------

// File: rtl/led_pattern_gen.sv
// LED pattern generator: steps an N-bit LED pattern once per prescaled tick
// in one of four run-time-selectable modes, and exports step/wrap pulses so
// other display logic can follow the sequence.
module led_pattern_gen #(
    parameter int WIDTH = 8,
    parameter int DIV   = 50_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] out,
    output logic             step,
    output logic             wrap
);

    localparam int                CW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]     CNT_MAX  = CW'(DIV - 1);
    localparam logic [WIDTH-1:0]  MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        FILL_L    = 2'd0,
        FILL_R    = 2'd1,
        RUN_DOT   = 2'd2,
        PING_PONG = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } dir_t;

    mode_t            mode_in;
    mode_t            mode_q;
    mode_t            mode_n;
    dir_t             dir;
    dir_t             dir_n;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_n;
    logic [WIDTH-1:0] out_n;
    logic [WIDTH-1:0] init_pat;
    logic             step_n;
    logic             wrap_n;
    logic             tick;
    logic             one_hot;

    assign mode_in = mode_t'(mode);
    assign tick    = en && (cnt == CNT_MAX);
    assign one_hot = (out != '0) && ((out & (out - WIDTH'(1))) == '0);

    // Starting pattern for the currently requested mode.
    always_comb begin
        init_pat = '0;
        if (mode_in == RUN_DOT || mode_in == PING_PONG) begin
            init_pat = MSB_ONLY;
        end
    end

    // Next-state logic: mode change beats a coincident tick; otherwise the
    // prescaler advances while enabled and the pattern steps on its tick.
    always_comb begin
        out_n  = out;
        mode_n = mode_q;
        cnt_n  = cnt;
        dir_n  = dir;
        step_n = 1'b0;
        wrap_n = 1'b0;
        if (mode_in != mode_q) begin
            out_n  = init_pat;
            mode_n = mode_in;
            cnt_n  = '0;
            dir_n  = DIR_RIGHT;
        end else if (en) begin
            cnt_n = tick ? '0 : cnt + CW'(1);
            if (tick) begin
                step_n = 1'b1;
                case (mode_q)
                    FILL_L: begin
                        if (&out) begin
                            out_n  = '0;
                            wrap_n = 1'b1;
                        end else begin
                            out_n = {1'b1, out[WIDTH-1:1]};
                        end
                    end
                    FILL_R: begin
                        if (&out) begin
                            out_n  = '0;
                            wrap_n = 1'b1;
                        end else begin
                            out_n = {out[WIDTH-2:0], 1'b1};
                        end
                    end
                    RUN_DOT: begin
                        if (!one_hot) begin
                            out_n  = MSB_ONLY;
                            wrap_n = 1'b1;
                        end else begin
                            out_n  = {out[0], out[WIDTH-1:1]};
                            wrap_n = out[0];
                        end
                    end
                    PING_PONG: begin
                        if (!one_hot) begin
                            out_n  = MSB_ONLY;
                            dir_n  = DIR_RIGHT;
                            wrap_n = 1'b1;
                        end else if (dir == DIR_RIGHT && !out[0]) begin
                            out_n = out >> 1;
                            if (out[1]) begin
                                dir_n = DIR_LEFT;
                            end
                        end else if (dir == DIR_LEFT && !out[WIDTH-1]) begin
                            out_n = out << 1;
                            if (out[WIDTH-2]) begin
                                dir_n  = DIR_RIGHT;
                                wrap_n = 1'b1;
                            end
                        end else if (dir == DIR_RIGHT) begin
                            // Dot already sits on the edge it is heading to: bounce.
                            out_n = out << 1;
                            dir_n = DIR_LEFT;
                        end else begin
                            out_n = out >> 1;
                            dir_n = DIR_RIGHT;
                        end
                    end
                endcase
            end
        end
    end

    // State register with synchronous reset to the requested mode's start.
    always_ff @(posedge clk) begin
        if (reset) begin
            out    <= init_pat;
            mode_q <= mode_in;
            cnt    <= '0;
            dir    <= DIR_RIGHT;
            step   <= 1'b0;
            wrap   <= 1'b0;
        end else begin
            out    <= out_n;
            mode_q <= mode_n;
            cnt    <= cnt_n;
            dir    <= dir_n;
            step   <= step_n;
            wrap   <= wrap_n;
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed testbench for led_pattern_gen: expected cycle-by-cycle outputs are
// queued as stimulus is planned and compared as the DUTs clock them out.
module tb_led_pattern_gen;

    logic       clk = 1'b0;

    logic       a_reset, a_en;
    logic [1:0] a_mode;
    logic [3:0] a_out;
    logic       a_step, a_wrap;

    logic       b_reset, b_en;
    logic [1:0] b_mode;
    logic [3:0] b_out;
    logic       b_step, b_wrap;

    logic       c_reset, c_en;
    logic [1:0] c_mode;
    logic [7:0] c_out;
    logic       c_step, c_wrap;

    typedef struct {
        logic [31:0] o;
        logic        s;
        logic        w;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   sel    = 0;

    led_pattern_gen #(.WIDTH(4), .DIV(1)) u_a (
        .clk(clk), .reset(a_reset), .en(a_en), .mode(a_mode),
        .out(a_out), .step(a_step), .wrap(a_wrap)
    );

    led_pattern_gen #(.WIDTH(4), .DIV(3)) u_b (
        .clk(clk), .reset(b_reset), .en(b_en), .mode(b_mode),
        .out(b_out), .step(b_step), .wrap(b_wrap)
    );

    led_pattern_gen #(.WIDTH(8), .DIV(2)) u_c (
        .clk(clk), .reset(c_reset), .en(c_en), .mode(c_mode),
        .out(c_out), .step(c_step), .wrap(c_wrap)
    );

    always #5 clk = ~clk;

    task automatic push(input logic [31:0] o, input logic s, input logic w, input string tag);
        exp_t e;
        e.o   = o;
        e.s   = s;
        e.w   = w;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic hold(input int n, input logic [31:0] o, input string tag);
        for (int i = 0; i < n; i++) begin
            push(o, 1'b0, 1'b0, tag);
        end
    endtask

    // One clock per queued entry; compare the selected DUT just after the edge.
    task automatic drain();
        exp_t        e;
        logic [31:0] ao;
        logic        as, aw;
        while (sb.size() > 0) begin
            @(posedge clk);
            #1;
            e = sb.pop_front();
            case (sel)
                0:       begin ao = {28'd0, a_out}; as = a_step; aw = a_wrap; end
                1:       begin ao = {28'd0, b_out}; as = b_step; aw = b_wrap; end
                default: begin ao = {24'd0, c_out}; as = c_step; aw = c_wrap; end
            endcase
            checks++;
            assert (ao === e.o) else begin
                errors++;
                $error("FAIL %s out: got %0h expected %0h", e.tag, ao, e.o);
            end
            checks++;
            assert (as === e.s) else begin
                errors++;
                $error("FAIL %s step: got %0b expected %0b", e.tag, as, e.s);
            end
            checks++;
            assert (aw === e.w) else begin
                errors++;
                $error("FAIL %s wrap: got %0b expected %0b", e.tag, aw, e.w);
            end
        end
    endtask

    initial begin
        logic [7:0] p;
        a_reset = 1'b1; a_en = 1'b0; a_mode = 2'd0;
        b_reset = 1'b1; b_en = 1'b0; b_mode = 2'd2;
        c_reset = 1'b1; c_en = 1'b0; c_mode = 2'd3;

        // Instance A: WIDTH=4, DIV=1
        sel = 0;
        push(32'h0, 1'b0, 1'b0, "a_reset");
        drain();
        a_reset = 1'b0;
        a_en    = 1'b1;
        push(32'h8, 1'b1, 1'b0, "fill_l_1");
        push(32'hc, 1'b1, 1'b0, "fill_l_2");
        push(32'he, 1'b1, 1'b0, "fill_l_3");
        push(32'hf, 1'b1, 1'b0, "fill_l_4");
        push(32'h0, 1'b1, 1'b1, "fill_l_wrap");
        push(32'h8, 1'b1, 1'b0, "fill_l_again1");
        push(32'hc, 1'b1, 1'b0, "fill_l_again2");
        drain();
        // out=1100 and a tick is due: the mode change wins
        a_mode = 2'd2;
        push(32'h8, 1'b0, 1'b0, "mode_switch");
        push(32'h4, 1'b1, 1'b0, "run_dot_1");
        push(32'h2, 1'b1, 1'b0, "run_dot_2");
        push(32'h1, 1'b1, 1'b0, "run_dot_3");
        push(32'h8, 1'b1, 1'b1, "run_dot_wrap");
        drain();
        a_mode = 2'd3;
        push(32'h8, 1'b0, 1'b0, "pp_enter");
        push(32'h4, 1'b1, 1'b0, "pp_1");
        push(32'h2, 1'b1, 1'b0, "pp_2");
        push(32'h1, 1'b1, 1'b0, "pp_3");
        push(32'h2, 1'b1, 1'b0, "pp_4");
        push(32'h4, 1'b1, 1'b0, "pp_5");
        push(32'h8, 1'b1, 1'b1, "pp_wrap");
        push(32'h4, 1'b1, 1'b0, "pp_repeat");
        drain();
        a_en   = 1'b0;
        a_mode = 2'd0;
        push(32'h0, 1'b0, 1'b0, "mode_en_low");
        push(32'h0, 1'b0, 1'b0, "hold_en_low");
        drain();

        // Instance B: WIDTH=4, DIV=3
        sel = 1;
        push(32'h8, 1'b0, 1'b0, "b_reset");
        drain();
        b_reset = 1'b0;
        b_en    = 1'b1;
        hold(2, 32'h8, "b_wait1");
        push(32'h4, 1'b1, 1'b0, "b_dot_1");
        hold(2, 32'h4, "b_wait2");
        push(32'h2, 1'b1, 1'b0, "b_dot_2");
        hold(2, 32'h2, "b_wait3");
        push(32'h1, 1'b1, 1'b0, "b_dot_3");
        hold(2, 32'h1, "b_wait4");
        push(32'h8, 1'b1, 1'b1, "b_dot_wrap");
        drain();
        b_mode = 2'd1;
        push(32'h0, 1'b0, 1'b0, "b_mode_fill_r");
        hold(2, 32'h0, "b_wait5");
        push(32'h1, 1'b1, 1'b0, "b_fill_r_1");
        hold(2, 32'h1, "b_wait6");
        push(32'h3, 1'b1, 1'b0, "b_fill_r_2");
        hold(1, 32'h3, "b_mid_count");
        drain();
        b_en = 1'b0;
        hold(5, 32'h3, "b_frozen");
        drain();
        b_en = 1'b1;
        hold(1, 32'h3, "b_resume");
        push(32'h7, 1'b1, 1'b0, "b_resume_step");
        hold(2, 32'h7, "b_wait7");
        push(32'hf, 1'b1, 1'b0, "b_fill_r_4");
        hold(2, 32'hf, "b_wait8");
        push(32'h0, 1'b1, 1'b1, "b_fill_r_wrap");
        drain();

        // Instance C: WIDTH=8, DIV=2, ping-pong
        sel = 2;
        push(32'h80, 1'b0, 1'b0, "c_reset");
        drain();
        c_reset = 1'b0;
        c_en    = 1'b1;
        p = 8'h80;
        for (int i = 0; i < 7; i++) begin
            hold(1, {24'd0, p}, "c_wait_r");
            p = p >> 1;
            push({24'd0, p}, 1'b1, 1'b0, "c_pp_right");
        end
        for (int i = 0; i < 2; i++) begin
            hold(1, {24'd0, p}, "c_wait_l");
            p = p << 1;
            push({24'd0, p}, 1'b1, 1'b0, "c_pp_left");
        end
        drain();
        // out=00000100 moving left; reset restarts moving right
        c_reset = 1'b1;
        push(32'h80, 1'b0, 1'b0, "c_reset_mid");
        drain();
        c_reset = 1'b0;
        hold(1, 32'h80, "c_wait_after_reset");
        push(32'h40, 1'b1, 1'b0, "c_after_reset");
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
